// File: rtl/dffram_128x32.sv
// dffram_128x32: single-port 128x32 flip-flop RAM (8 banks x 16 words), per-byte write enables.
// Latency: read data registered, valid one cycle after A0 is sampled; read-before-write on collisions.
// Backpressure: none; EN0=0 freezes memory and Do0. DFFRAM_CLEAR_ON_RESET_EN makes RST also zero every word.
module dffram_128x32 #(
  parameter int WSIZE = 4,
  parameter int BANKS = 8,
  localparam int DW     = 8 * WSIZE,
  localparam int BW     = $clog2(BANKS),
  localparam int AWIDTH = BW + 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN0,
  input  logic [WSIZE-1:0]  WE0,
  input  logic [AWIDTH-1:0] A0,
  input  logic [DW-1:0]     Di0,
  output logic [DW-1:0]     Do0
);

  logic [BW-1:0] bank_sel;
  logic [3:0]    word_sel;
  logic          wr_en;
  logic [DW-1:0] bank_rd [BANKS];
  logic [DW-1:0] rd_word;

  assign bank_sel = A0[AWIDTH-1:4];
  assign word_sel = A0[3:0];
  // Reset wins over any write in the same cycle.
  assign wr_en    = EN0 & ~RST;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DW-1:0]    words [16];
    logic [WSIZE-1:0] be;

    assign be = (wr_en && (bank_sel == BW'(b))) ? WE0 : '0;

    always_ff @(posedge CLK) begin
`ifdef DFFRAM_CLEAR_ON_RESET_EN
      if (RST) begin
        for (int w = 0; w < 16; w++) begin
          words[w] <= '0;
        end
      end else begin
        for (int i = 0; i < WSIZE; i++) begin
          if (be[i]) words[word_sel][8*i +: 8] <= Di0[8*i +: 8];
        end
      end
`else
      for (int i = 0; i < WSIZE; i++) begin
        if (be[i]) words[word_sel][8*i +: 8] <= Di0[8*i +: 8];
      end
`endif
    end

    assign bank_rd[b] = words[word_sel];
  end

  assign rd_word = bank_rd[bank_sel];

  // Sampling rd_word at the same edge as the write yields the pre-write contents.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Do0 <= '0;
    end else if (EN0) begin
      Do0 <= rd_word;
    end
  end

endmodule

// File: tb/tb_dffram_128x32.sv
// Scoreboard bench for dffram_128x32: stimulus queues expected Do0 values, a monitor compares them.
module tb_dffram_128x32;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN0 = 1'b0;
  logic [3:0]  WE0 = 4'h0;
  logic [6:0]  A0  = 7'h0;
  logic [31:0] Di0 = 32'h0;
  logic [31:0] Do0;

  logic [31:0] exp_q [$];
  string       name_q [$];
  logic        chk_req   = 1'b0;
  logic        chk_fire  = 1'b0;
  logic        finishing = 1'b0;
  int          checks = 0;
  int          errors = 0;

  dffram_128x32 dut (
    .CLK (CLK),
    .RST (RST),
    .EN0 (EN0),
    .WE0 (WE0),
    .A0  (A0),
    .Di0 (Di0),
    .Do0 (Do0)
  );

  always #5 CLK = ~CLK;

  // Marks that the edge just taken should have produced a checked Do0.
  always @(posedge CLK) chk_fire <= chk_req;

  always @(negedge CLK) begin
    if (chk_fire) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: Do0=%08h with no expected value queued", Do0);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (Do0 !== e) begin
          errors++;
          $display("FAIL %s: Do0=%08h expected %08h", n, Do0, e);
        end
      end
    end else if (finishing && exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expected values never observed", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  end

  task automatic cyc(input logic rst, input logic en, input logic [3:0] we,
                     input logic [6:0] a, input logic [31:0] di,
                     input logic chk, input logic [31:0] e, input string n);
    @(negedge CLK);
    RST = rst; EN0 = en; WE0 = we; A0 = a; Di0 = di;
    chk_req = chk;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(n);
    end
    @(posedge CLK);
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] di, input logic [3:0] we);
    cyc(1'b0, 1'b1, we, a, di, 1'b0, 32'h0, "");
  endtask

  task automatic rd(input logic [6:0] a, input logic [31:0] e, input string n);
    cyc(1'b0, 1'b1, 4'h0, a, 32'h0, 1'b1, e, n);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'h0, 7'h0, 32'h0, 1'b0, 32'h0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] post_rst0, post_rst3, post_rst12;
`ifdef DFFRAM_CLEAR_ON_RESET_EN
    post_rst0 = 32'h0; post_rst3 = 32'h0; post_rst12 = 32'h0;
`else
    post_rst0 = 32'hAA3355BB; post_rst3 = 32'h22222222; post_rst12 = 32'hAA005533;
`endif

    cyc(1'b1, 1'b0, 4'h0, 7'h0, 32'h0, 1'b1, 32'h0, "reset_do0");
    idle();

    // Bank 0 full-word writes, then byte masks
    wr(7'h00, 32'hAA0055BB, 4'b1111);
    wr(7'h01, 32'hAA0055CC, 4'b1111);
    wr(7'h02, 32'hAA0055DD, 4'b1111);
    rd(7'h00, 32'hAA0055BB, "b0_full_0x00");
    wr(7'h02, 32'h00000033, 4'b0001);
    wr(7'h01, 32'h00003300, 4'b0010);
    wr(7'h00, 32'h00330000, 4'b0100);
    rd(7'h00, 32'hAA3355BB, "b0_mask_0x00");
    rd(7'h01, 32'hAA0033CC, "b0_mask_0x01");
    rd(7'h02, 32'hAA005533, "b0_mask_0x02");

    // Bank 1 repeat, then confirm bank 0 untouched
    wr(7'h10, 32'hAA0055BB, 4'b1111);
    wr(7'h11, 32'hAA0055CC, 4'b1111);
    wr(7'h12, 32'hAA0055DD, 4'b1111);
    rd(7'h10, 32'hAA0055BB, "b1_full_0x10");
    wr(7'h12, 32'h00000033, 4'b0001);
    wr(7'h11, 32'h00003300, 4'b0010);
    wr(7'h10, 32'h00330000, 4'b0100);
    rd(7'h10, 32'hAA3355BB, "b1_mask_0x10");
    rd(7'h11, 32'hAA0033CC, "b1_mask_0x11");
    rd(7'h12, 32'hAA005533, "b1_mask_0x12");
    rd(7'h00, 32'hAA3355BB, "b0_iso_0x00");
    rd(7'h01, 32'hAA0033CC, "b0_iso_0x01");
    rd(7'h02, 32'hAA005533, "b0_iso_0x02");

    // Bank 7: masked-off AB bytes must never land
    wr(7'h70, 32'hF0F055BB, 4'b1111);
    wr(7'h71, 32'hF0F055CC, 4'b1111);
    wr(7'h72, 32'hF0F055DD, 4'b1111);
    wr(7'h72, 32'hAB000033, 4'b0001);
    wr(7'h71, 32'hAB003300, 4'b0010);
    wr(7'h70, 32'hAB330000, 4'b0100);
    rd(7'h70, 32'hF03355BB, "b7_mask_0x70");
    rd(7'h71, 32'hF0F033CC, "b7_mask_0x71");
    rd(7'h72, 32'hF0F05533, "b7_mask_0x72");
    rd(7'h12, 32'hAA005533, "b1_iso_0x12");

    // EN0=0 blocks the write and holds Do0
    wr(7'h05, 32'hCAFEF00D, 4'b1111);
    rd(7'h05, 32'hCAFEF00D, "en_pre_0x05");
    cyc(1'b0, 1'b0, 4'b1111, 7'h05, 32'h12345678, 1'b1, 32'hCAFEF00D, "en0_hold_do0");
    rd(7'h05, 32'hCAFEF00D, "en0_no_write_0x05");

    // Read-during-write returns old data
    wr(7'h03, 32'h11111111, 4'b1111);
    cyc(1'b0, 1'b1, 4'b1111, 7'h03, 32'h22222222, 1'b1, 32'h11111111, "rdw_old_0x03");
    rd(7'h03, 32'h22222222, "rdw_new_0x03");

    // Reset with a write pending: Do0 cleared, write suppressed
    cyc(1'b1, 1'b1, 4'b1111, 7'h03, 32'hDEADBEEF, 1'b1, 32'h0, "reset_pulse_do0");
    rd(7'h00, post_rst0, "post_reset_0x00");
    rd(7'h03, post_rst3, "post_reset_0x03");
    rd(7'h12, post_rst12, "post_reset_0x12");

    idle();
    finishing = 1'b1;
    repeat (3) idle();
    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
